// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are reduced to magnitudes and the product sign is applied in SIGN.
module seq_mult_hs #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           busy
);

  localparam int PW = 2 * N;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_SIGN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_mag_a;
  logic [N-1:0]   r_mag_b;
  logic           r_neg;
  logic [PW-1:0]  r_acc;
  logic [CW-1:0]  r_cnt;
  logic [PW-1:0]  r_out;

  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic [PW-1:0]  w_addend;

  // -2^(N-1) negates to itself, which read as unsigned is exactly its magnitude.
  assign w_mag_a  = (is_signed && A[N-1]) ? -A : A;
  assign w_mag_b  = (is_signed && B[N-1]) ? -B : B;
  assign w_addend = PW'(r_mag_a) << r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_MULT;
      end
      S_MULT: begin
        busy = 1'b1;
        if (r_cnt == CNT_LAST) w_next = S_SIGN;
      end
      S_SIGN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= is_signed & (A[N-1] ^ B[N-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_MULT: begin
          if (r_mag_b[0]) r_acc <= r_acc + w_addend;
          r_mag_b <= r_mag_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
        end
        S_SIGN: begin
          // A zero accumulator negates to zero, so no negative zero appears.
          r_out <= r_neg ? -r_acc : r_acc;
        end
        default: ;
      endcase
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed bench for seq_mult_hs (N=5): handshakes, sign handling, back-pressure
// and asynchronous reset, with expected products worked out by hand or by a model.
module tb_seq_mult_hs;

  localparam int N = 5;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out;
  logic           busy;

  int total;
  int bad;

  seq_mult_hs #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic s);
    int x;
    if (s) x = int'($signed(a)) * int'($signed(b));
    else   x = int'(a) * int'(b);
    return x[2*N-1:0];
  endfunction

  // Starts and ends on a falling edge. Operands are scrambled right after the
  // accepting edge; lat counts rising edges from acceptance to out_valid.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input logic rdy, output logic [2*N-1:0] p, output int lat,
                        output int busy_cyc, output bit timed_out);
    int w;
    timed_out = 1'b0;
    out_ready = rdy;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); @(negedge clk); w++;
    end
    if (!in_ready) timed_out = 1'b1;
    A = a; B = b; is_signed = s; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    A         = N'($urandom);
    B         = N'($urandom);
    is_signed = ~s;
    lat = 0;
    busy_cyc = 0;
    while (!out_valid && lat < 50) begin
      if (busy) busy_cyc++;
      @(posedge clk); @(negedge clk); lat++;
    end
    if (!out_valid) timed_out = 1'b1;
    p = out;
    if (rdy) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; is_signed = 1'b0; out_ready = 1'b0;
    #12;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctrl: got ready/valid/busy=%b want 100", {in_ready, out_valid, busy});
    end
    total++;
    if (out !== '0) begin
      bad++;
      $display("FAIL reset_out: got %h want 000", out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_signed_basic();
    logic [2*N-1:0] p; int lat; int bc; bit to;
    run_op(5'b00111, 5'b11101, 1'b1, 1'b1, p, lat, bc, to);
    total++;
    if (to || p !== 10'h3EB) begin
      bad++;
      $display("FAIL signed_7x-3: got %h (timeout=%0d) want 3eb", p, to);
    end
    total++;
    if (lat !== 6) begin
      bad++;
      $display("FAIL latency: got %0d edges want 6", lat);
    end
    total++;
    if (bc !== 6) begin
      bad++;
      $display("FAIL busy_cycles: got %0d want 6", bc);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL return_idle: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_extremes();
    logic [2*N-1:0] p; int lat; int bc; bit to;
    run_op(5'b10000, 5'b10000, 1'b1, 1'b1, p, lat, bc, to);
    total++;
    if (to || p !== 10'h100) begin
      bad++;
      $display("FAIL signed_-16x-16: got %h want 100", p);
    end
    run_op(5'b10000, 5'b01111, 1'b1, 1'b1, p, lat, bc, to);
    total++;
    if (to || p !== 10'h310) begin
      bad++;
      $display("FAIL signed_-16x15: got %h want 310", p);
    end
  endtask

  task automatic test_unsigned();
    logic [2*N-1:0] p; int lat; int bc; bit to;
    run_op(5'b11111, 5'b11111, 1'b0, 1'b1, p, lat, bc, to);
    total++;
    if (to || p !== 10'h3C1) begin
      bad++;
      $display("FAIL unsigned_31x31: got %h want 3c1", p);
    end
    run_op(5'b11111, 5'b11111, 1'b1, 1'b1, p, lat, bc, to);
    total++;
    if (to || p !== 10'h001) begin
      bad++;
      $display("FAIL signed_-1x-1: got %h want 001", p);
    end
  endtask

  task automatic test_backpressure();
    logic [2*N-1:0] p; int lat; int bc; bit to;
    run_op(5'b01011, 5'b00110, 1'b0, 1'b0, p, lat, bc, to);
    total++;
    if (to || p !== 10'h042) begin
      bad++;
      $display("FAIL bp_product: got %h want 042", p);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 10'h042) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b out=%h want 1 0 042",
                 i, out_valid, in_ready, out);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 10'h042) begin
      bad++;
      $display("FAIL bp_release: got ready=%b valid=%b out=%h want 1 0 042",
               in_ready, out_valid, out);
    end
  endtask

  task automatic test_random_stream();
    logic [2*N-1:0] p; int lat; int bc; bit to;
    logic [N-1:0] a; logic [N-1:0] b; logic s;
    for (int i = 0; i < 20; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      s = 1'($urandom);
      run_op(a, b, s, 1'b1, p, lat, bc, to);
      total++;
      if (to || p !== ref_mul(a, b, s)) begin
        bad++;
        $display("FAIL rand[%0d] %h*%h s=%b: got %h want %h", i, a, b, s, p, ref_mul(a, b, s));
      end
    end
  endtask

  task automatic test_zero_sign();
    logic [2*N-1:0] p; int lat; int bc; bit to;
    run_op(5'b00000, 5'b11011, 1'b1, 1'b1, p, lat, bc, to);
    total++;
    if (to || p !== 10'h000) begin
      bad++;
      $display("FAIL zero_x-5: got %h want 000", p);
    end
    run_op(5'b00101, 5'b11111, 1'b1, 1'b1, p, lat, bc, to);
    total++;
    if (to || p !== 10'h3FB) begin
      bad++;
      $display("FAIL signed_5x-1: got %h want 3fb", p);
    end
  endtask

  task automatic test_async_reset();
    logic [2*N-1:0] p; int lat; int bc; bit to;
    A = 5'b01101; B = 5'b01011; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1 || out !== 10'h3FB) begin
      bad++;
      $display("FAIL pre_reset: got busy=%b out=%h want 1 3fb", busy, out);
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b ready=%b busy=%b out=%h want 0 1 0 000",
               out_valid, in_ready, busy, out);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(5'b00011, 5'b00100, 1'b0, 1'b1, p, lat, bc, to);
    total++;
    if (to || p !== 10'h00C) begin
      bad++;
      $display("FAIL post_reset_3x4: got %h want 00c", p);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_signed_basic();
    test_extremes();
    test_unsigned();
    test_backpressure();
    test_random_stream();
    test_zero_sign();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
